eb_upsize: RTL and testbench

EB_UPSIZE -- requirements
Module: eb_upsize

---
 rtl/eb_pkg.sv | 23 ++
 rtl/eb_upsize_lanes.sv | 60 ++++++
 rtl/eb_upsize.sv | 77 +++++++
 tb/tb_eb_upsize.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/eb_pkg.sv
// Shared definitions for the elastic-buffer width converters: FSM states,
// legal ratio range and the lane-index width helper.
package eb_pkg;

  localparam int RATIO_MIN = 2;
  localparam int RATIO_MAX = 16;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } eb_state_e;

  // Bits needed to index value lanes; never less than one so a counter always exists.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/eb_upsize_lanes.sv
// Lane storage for the upsizer: one DWIDTH register plus keep bit per lane,
// written by lane index and cleared wholesale when a finished word leaves.
module eb_upsize_lanes
  import eb_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int RATIO  = 4,
  parameter int CW     = clog2(RATIO)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_write,
  input  logic [CW-1:0]            i_lane,
  input  logic [DWIDTH-1:0]        i_beat,
  output logic [DWIDTH*RATIO-1:0]  o_data,
  output logic [RATIO-1:0]         o_keep
);

  logic [RATIO-1:0]  w_laneWe;
  logic [DWIDTH-1:0] r_lane [RATIO];
  logic [RATIO-1:0]  r_keep;

  always_comb begin
    w_laneWe = '0;
    for (int k = 0; k < RATIO; k++) begin
      w_laneWe[k] = i_write && (i_lane == CW'(k));
    end
  end

  // A write wins over a clear so a beat arriving with the pop starts the fresh word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < RATIO; k++) begin
        r_lane[k] <= '0;
      end
      r_keep <= '0;
    end else begin
      for (int k = 0; k < RATIO; k++) begin
        if (w_laneWe[k]) begin
          r_lane[k] <= i_beat;
          r_keep[k] <= 1'b1;
        end else if (i_clear) begin
          r_lane[k] <= '0;
          r_keep[k] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    o_data = '0;
    for (int k = 0; k < RATIO; k++) begin
      o_data[k*DWIDTH +: DWIDTH] = r_lane[k];
    end
  end

  assign o_keep = r_keep;

endmodule

// File: rtl/eb_upsize.sv
// Narrow-to-wide stream upsizer: packs RATIO beats of DWIDTH bits into one
// wide word, closing a word early on t_last.
module eb_upsize
  import eb_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int RATIO  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DWIDTH-1:0]        t_data,
  input  logic                     t_valid,
  input  logic                     t_last,
  output logic                     t_ready,
  output logic [DWIDTH*RATIO-1:0]  i_data,
  output logic [RATIO-1:0]         i_keep,
  output logic                     i_last,
  output logic                     i_valid,
  input  logic                     i_ready
);

  localparam int            CW       = clog2(RATIO);
  localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  eb_state_e     r_state;
  logic [CW-1:0] r_cnt;
  logic          r_last;

  logic w_accept;
  logic w_pop;
  logic w_complete;

  assign i_valid    = (r_state == FULL);
  assign i_last     = r_last;
  assign t_ready    = ~i_valid | i_ready;
  assign w_accept   = t_valid & t_ready;
  assign w_pop      = i_valid & i_ready;
  assign w_complete = w_accept & (t_last | (r_cnt == CNT_LAST));

  // r_cnt is always 0 in FULL, so a beat accepted alongside a pop lands in lane 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
      r_cnt   <= '0;
      r_last  <= 1'b0;
    end else if (w_complete) begin
      r_state <= FULL;
      r_cnt   <= '0;
      r_last  <= t_last;
    end else if (w_accept) begin
      r_state <= FILL;
      r_cnt   <= r_cnt + CNT_ONE;
      r_last  <= 1'b0;
    end else if (w_pop) begin
      r_state <= FILL;
      r_cnt   <= '0;
      r_last  <= 1'b0;
    end
  end

  eb_upsize_lanes #(
    .DWIDTH (DWIDTH),
    .RATIO  (RATIO),
    .CW     (CW)
  ) u_lanes (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_pop),
    .i_write (w_accept),
    .i_lane  (r_cnt),
    .i_beat  (t_data),
    .o_data  (i_data),
    .o_keep  (i_keep)
  );

endmodule

// File: tb/tb_eb_upsize.sv
// Self-checking bench for eb_upsize (DWIDTH=8, RATIO=4): directed scenarios
// plus randomized traffic against a queue-based packing model.
module tb_eb_upsize;

  localparam int DW = 8;
  localparam int RT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  t_data;
  logic        t_valid;
  logic        t_last;
  logic        t_ready;
  logic [31:0] i_data;
  logic [3:0]  i_keep;
  logic        i_last;
  logic        i_valid;
  logic        i_ready;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mBeats [$];
  logic        mPend;
  logic        mPendLast;
  logic        mReadyExp;

  logic [31:0] sData;
  logic [3:0]  sKeep;
  logic        sLast;
  logic        sValid;
  logic        sReady;
  logic [35:0] emitted [$];

  eb_upsize #(.DWIDTH(DW), .RATIO(RT)) dut (
    .clk     (clk),
    .rst     (rst),
    .t_data  (t_data),
    .t_valid (t_valid),
    .t_last  (t_last),
    .t_ready (t_ready),
    .i_data  (i_data),
    .i_keep  (i_keep),
    .i_last  (i_last),
    .i_valid (i_valid),
    .i_ready (i_ready)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // The visible word is simply the beats gathered so far, packed low lane first.
  task automatic checkOutput();
    logic [31:0] expData;
    logic [3:0]  expKeep;
    expData = '0;
    foreach (mBeats[k]) expData = expData | (32'(mBeats[k]) << (8 * k));
    expKeep   = 4'((1 << mBeats.size()) - 1);
    mReadyExp = !mPend || i_ready;
    checkValue("t_ready", 32'(t_ready), 32'(mReadyExp));
    checkValue("i_valid", 32'(i_valid), 32'(mPend));
    checkValue("i_last",  32'(i_last),  32'(mPend ? mPendLast : 1'b0));
    checkValue("i_keep",  32'(i_keep),  32'(expKeep));
    checkValue("i_data",  i_data,       expData);
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l,
                               input logic rdy, input logic rs);
    logic accept;
    logic pop;
    t_valid = v;
    t_data  = d;
    t_last  = l;
    i_ready = rdy;
    rst     = rs;
    @(negedge clk);
    sData  = i_data;
    sKeep  = i_keep;
    sLast  = i_last;
    sValid = i_valid;
    sReady = t_ready;
    checkOutput();
    if (i_valid && i_ready && !rs) emitted.push_back({i_keep, i_data});
    accept = v && mReadyExp && !rs;
    pop    = mPend && rdy && !rs;
    @(posedge clk);
    if (rs) begin
      mBeats.delete();
      mPend     = 1'b0;
      mPendLast = 1'b0;
    end else begin
      if (pop) begin
        mBeats.delete();
        mPend     = 1'b0;
        mPendLast = 1'b0;
      end
      if (accept) begin
        mBeats.push_back(d);
        if (mBeats.size() == RT || l) begin
          mPend     = 1'b1;
          mPendLast = l;
        end
      end
    end
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    t_valid = 1'b0;
    t_data  = '0;
    t_last  = 1'b0;
    i_ready = 1'b0;
    mPend     = 1'b0;
    mPendLast = 1'b0;
    mReadyExp = 1'b1;
    @(posedge clk);
    #1;

    // Reset: ready stays high but an offered beat is not captured.
    applyStimulus(1'b1, 8'hEE, 1'b1, 1'b1, 1'b1);
    checkValue("reset t_ready", 32'(sReady), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkValue("reset i_keep", 32'(sKeep), 32'd0);
    checkValue("reset i_valid", 32'(sValid), 32'd0);

    // Full word with t_last on the fourth beat.
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h44, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkValue("w1 valid", 32'(sValid), 32'd1);
    checkValue("w1 data", sData, 32'h44332211);
    checkValue("w1 keep", 32'(sKeep), 32'hF);
    checkValue("w1 last", 32'(sLast), 32'd1);

    // Short packet.
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hBB, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkValue("short data", sData, 32'h0000BBAA);
    checkValue("short keep", 32'(sKeep), 32'h3);
    checkValue("short last", 32'(sLast), 32'd1);

    // Back-to-back beats with no bubbles.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
      checkValue("stream t_ready", 32'(sReady), 32'd1);
      if (i == 5) begin
        checkValue("stream w0 valid", 32'(sValid), 32'd1);
        checkValue("stream w0 data", sData, 32'h04030201);
      end
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkValue("stream w1 data", sData, 32'h08070605);
    checkValue("stream w1 last", 32'(sLast), 32'd0);

    // Backpressure on a full word, then a beat accepted alongside the pop.
    applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hA4, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
      checkValue("stall t_ready", 32'(sReady), 32'd0);
      checkValue("stall data", sData, 32'hA4A3A2A1);
    end
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
    checkValue("release t_ready", 32'(sReady), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkValue("fresh valid", 32'(sValid), 32'd0);
    checkValue("fresh keep", 32'(sKeep), 32'h1);
    checkValue("fresh data", sData, 32'h00000055);
    applyStimulus(1'b1, 8'h66, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkValue("fresh close data", sData, 32'h00006655);

    // Single-beat packet.
    applyStimulus(1'b1, 8'h7E, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkValue("single data", sData, 32'h0000007E);
    checkValue("single keep", 32'(sKeep), 32'h1);
    checkValue("single last", 32'(sLast), 32'd1);

    // Reset mid-packet discards the partial word.
    emitted.delete();
    applyStimulus(1'b1, 8'h10, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h20, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkValue("reset-mid count", 32'(emitted.size()), 32'd1);
    if (emitted.size() > 0) begin
      checkValue("reset-mid data", emitted[0][31:0], 32'h34333231);
      checkValue("reset-mid keep", 32'(emitted[0][35:32]), 32'hF);
    end

    // Randomized traffic, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 4) == 0,
                    $urandom_range(0, 9) < 6, $urandom_range(0, 99) == 0);
    end
    repeat (6) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
